// File: rtl/cpu_types_pkg.sv
// Shared types for the coherence bus controller: RAM status, bus FSM states
// and the grant-type encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    DRAM  = 2'd2,
    IRAM  = 2'd3
  } bus_state_t;

  localparam logic GT_I = 1'b0;
  localparam logic GT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request searching upward from last+1, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] grant_o,
  output logic         valid_o
);

  always_comb begin
    int idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shares one RAM port among the icaches and dcaches of CPUS cores, with dcache
// priority, round-robin among cores, a one-cycle snoop broadcast and burst lock.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [32*CPUS-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [32*CPUS-1:0]  iload,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [32*CPUS-1:0]  daddr,
  input  logic [32*CPUS-1:0]  dstore,
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     dwait,
  output logic [32*CPUS-1:0]  dload,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [32*CPUS-1:0]  ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WW = $clog2(BLOCK_WORDS) + 1;

  bus_state_t    st_q, st_d, st_eff;
  logic [CW-1:0] gcore_q, gcore_d, rr_q, rr_d;
  logic          gtype_q, gtype_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic [31:0]   iaddr_a [CPUS];
  logic [31:0]   daddr_a [CPUS];
  logic [31:0]   dstore_a [CPUS];

  for (genvar c = 0; c < CPUS; c++) begin : g_split
    assign iaddr_a[c]  = iaddr[32*c +: 32];
    assign daddr_a[c]  = daddr[32*c +: 32];
    assign dstore_a[c] = dstore[32*c +: 32];
  end

  logic [CW-1:0] d_grant, i_grant;
  logic          d_valid, i_valid;

  rr_arbiter #(.N(CPUS), .W(CW)) u_arb_d (
    .req_i(dREN | dWEN), .last_i(rr_q), .grant_o(d_grant), .valid_o(d_valid)
  );

  rr_arbiter #(.N(CPUS), .W(CW)) u_arb_i (
    .req_i(iREN), .last_i(rr_q), .grant_o(i_grant), .valid_o(i_valid)
  );

  logic own_req, acc;
  assign own_req = (gtype_q == GT_D) ? (dREN[gcore_q] | dWEN[gcore_q]) : iREN[gcore_q];
  assign acc     = (ramstate == RAM_ACCESS);
  // Reset is synchronous, so outputs are forced idle during the reset cycle
  // itself to abort any transaction without a stray wait pulse.
  assign st_eff  = RST ? IDLE : st_q;

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (own_req) begin
      case (st_eff)
        SNOOP: begin
          for (int k = 0; k < CPUS; k++) begin
            if (k != int'(gcore_q)) begin
              ccwait[k]              = 1'b1;
              ccinv[k]               = ccwrite[gcore_q];
              ccsnoopaddr[32*k +: 32] = daddr_a[gcore_q];
            end
          end
        end
        DRAM: begin
          ramWEN   = dWEN[gcore_q];
          ramREN   = ~dWEN[gcore_q];
          ramaddr  = daddr_a[gcore_q];
          ramstore = dstore_a[gcore_q];
          for (int k = 0; k < CPUS; k++) begin
            if (k != int'(gcore_q)) ccwait[k] = cctrans[gcore_q];
          end
          if (acc) begin
            dwait[gcore_q]           = 1'b0;
            dload[32*gcore_q +: 32]  = ramload;
          end
        end
        IRAM: begin
          ramREN  = 1'b1;
          ramaddr = iaddr_a[gcore_q];
          if (acc) begin
            iwait[gcore_q]          = 1'b0;
            iload[32*gcore_q +: 32] = ramload;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d    = st_q;
    gcore_d = gcore_q;
    gtype_d = gtype_q;
    rr_d    = rr_q;
    wcnt_d  = wcnt_q;
    case (st_q)
      IDLE: begin
        if (d_valid) begin
          gcore_d = d_grant;
          gtype_d = GT_D;
          st_d    = (!dWEN[d_grant] && cctrans[d_grant]) ? SNOOP : DRAM;
        end else if (i_valid) begin
          gcore_d = i_grant;
          gtype_d = GT_I;
          st_d    = IRAM;
        end
      end
      SNOOP: begin
        if (!own_req) begin
          st_d = IDLE;
          rr_d = gcore_q;
        end else begin
          st_d = DRAM;
        end
      end
      DRAM: begin
        if (!own_req) begin
          st_d   = IDLE;
          rr_d   = gcore_q;
          wcnt_d = '0;
        end else if (acc) begin
          if (int'(wcnt_q) + 1 < BLOCK_WORDS) begin
            wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
          end else begin
            st_d   = IDLE;
            rr_d   = gcore_q;
            wcnt_d = '0;
          end
        end
      end
      IRAM: begin
        if (!own_req || acc) begin
          st_d = IDLE;
          rr_d = gcore_q;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      gcore_q <= '0;
      gtype_q <= GT_I;
      rr_q    <= CW'(CPUS - 1);
      wcnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      gcore_q <= gcore_d;
      gtype_q <= gtype_d;
      rr_q    <= rr_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: instance a uses BLOCK_WORDS=2,
// instance b uses BLOCK_WORDS=1 for the round-robin sequence.
module tb_coherence_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  logic [63:0] iaddr, daddr, dstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic [1:0]  a_iwait, a_dwait, a_ccwait, a_ccinv;
  logic [63:0] a_iload, a_dload, a_ccsnoopaddr;
  logic        a_ramREN, a_ramWEN;
  logic [31:0] a_ramaddr, a_ramstore;

  logic [1:0]  b_iwait, b_dwait, b_ccwait, b_ccinv;
  logic [63:0] b_iload, b_dload, b_ccsnoopaddr;
  logic        b_ramREN, b_ramWEN;
  logic [31:0] b_ramaddr, b_ramstore;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(2), .BLOCK_WORDS(2)) dut_a (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(a_iwait), .iload(a_iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cctrans(cctrans),
    .ccwrite(ccwrite), .dwait(a_dwait), .dload(a_dload), .ccwait(a_ccwait), .ccinv(a_ccinv),
    .ccsnoopaddr(a_ccsnoopaddr), .ramREN(a_ramREN), .ramWEN(a_ramWEN), .ramaddr(a_ramaddr),
    .ramstore(a_ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  coherence_bus_ctrl #(.CPUS(2), .BLOCK_WORDS(1)) dut_b (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(b_iwait), .iload(b_iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cctrans(cctrans),
    .ccwrite(ccwrite), .dwait(b_dwait), .dload(b_dload), .ccwait(b_ccwait), .ccinv(b_ccinv),
    .ccsnoopaddr(b_ccsnoopaddr), .ramREN(b_ramREN), .ramWEN(b_ramWEN), .ramaddr(b_ramaddr),
    .ramstore(b_ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    clr_in();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK); #1;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_iwait"}, a_iwait, 2'b11);
    chk({pfx, "_dwait"}, a_dwait, 2'b11);
    chk({pfx, "_ccwait"}, a_ccwait, 2'b00);
    chk({pfx, "_ccinv"}, a_ccinv, 2'b00);
    chk({pfx, "_ramREN"}, a_ramREN, 1'b0);
    chk({pfx, "_ramWEN"}, a_ramWEN, 1'b0);
    chk({pfx, "_ramaddr"}, a_ramaddr, 32'h0);
    chk({pfx, "_ramstore"}, a_ramstore, 32'h0);
    chk({pfx, "_snoopaddr"}, a_ccsnoopaddr, 64'h0);
    chk({pfx, "_iload"}, a_iload, 64'h0);
    chk({pfx, "_dload"}, a_dload, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset();
    smp();
    chk_reset_outs("rst");
    adv();

    // single I fetch: two BUSY then ACCESS
    iREN = 2'b01; iaddr[31:0] = 32'h40;
    smp(); chk("if_idle_ren", a_ramREN, 1'b0); chk("if_idle_iwait", a_iwait, 2'b11); adv();
    ramstate = 2'd1;
    smp(); chk("if_b1_ren", a_ramREN, 1'b1); chk("if_b1_addr", a_ramaddr, 32'h40);
    chk("if_b1_iwait", a_iwait, 2'b11); adv();
    smp(); chk("if_b2_ren", a_ramREN, 1'b1); chk("if_b2_iwait", a_iwait, 2'b11); adv();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    smp(); chk("if_acc_iwait", a_iwait, 2'b10); chk("if_acc_iload", a_iload, 64'hDEADBEEF);
    chk("if_acc_ren", a_ramREN, 1'b1); adv();
    iREN = 2'b00; ramstate = 2'd0;
    smp(); chk("if_done_iwait", a_iwait, 2'b11); chk("if_done_ren", a_ramREN, 1'b0); adv();

    // D priority over I
    do_reset();
    iREN = 2'b01; iaddr[31:0] = 32'h80; dREN = 2'b10; daddr[63:32] = 32'h300;
    smp(); chk("pr_idle_ren", a_ramREN, 1'b0); adv();
    ramstate = 2'd2; ramload = 32'h11;
    smp(); chk("pr_d_addr", a_ramaddr, 32'h300); chk("pr_d_ren", a_ramREN, 1'b1);
    chk("pr_d_dwait", a_dwait, 2'b01); chk("pr_d_dload", a_dload, 64'h00000011_00000000);
    chk("pr_d_iwait", a_iwait, 2'b11); adv();
    dREN = 2'b00;
    smp(); chk("pr_drop_ren", a_ramREN, 1'b0); chk("pr_drop_dwait", a_dwait, 2'b11); adv();
    ramstate = 2'd0;
    smp(); chk("pr_idle2_iwait", a_iwait, 2'b11); adv();
    ramstate = 2'd2; ramload = 32'h22;
    smp(); chk("pr_i_addr", a_ramaddr, 32'h80); chk("pr_i_iwait", a_iwait, 2'b10);
    chk("pr_i_iload", a_iload, 64'h22); adv();
    iREN = 2'b00; ramstate = 2'd0;

    // round-robin with BLOCK_WORDS=1 (instance b)
    do_reset();
    dWEN = 2'b11; daddr = {32'h2000, 32'h1000}; dstore = {32'hB1, 32'hA0}; ramstate = 2'd2;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (i % 2 == 0) begin
        chk("rr_idle_dwait", b_dwait, 2'b11);
        chk("rr_idle_wen", b_ramWEN, 1'b0);
      end else if ((i / 2) % 2 == 0) begin
        chk("rr_c0_dwait", b_dwait, 2'b10);
        chk("rr_c0_addr", b_ramaddr, 32'h1000);
        chk("rr_c0_wen", b_ramWEN, 1'b1);
      end else begin
        chk("rr_c1_dwait", b_dwait, 2'b01);
        chk("rr_c1_addr", b_ramaddr, 32'h2000);
        chk("rr_c1_store", b_ramstore, 32'hB1);
      end
      adv();
    end

    // snoop with invalidate
    do_reset();
    dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[31:0] = 32'h100; ramstate = 2'd1;
    smp(); chk("sn_idle_ccwait", a_ccwait, 2'b00); adv();
    smp(); chk("sn_ccwait", a_ccwait, 2'b10); chk("sn_ccinv", a_ccinv, 2'b10);
    chk("sn_snoopaddr", a_ccsnoopaddr, 64'h00000100_00000000); chk("sn_ren", a_ramREN, 1'b0); adv();
    smp(); chk("sn_dram_ren", a_ramREN, 1'b1); chk("sn_dram_addr", a_ramaddr, 32'h100);
    chk("sn_dram_ccwait", a_ccwait, 2'b10); chk("sn_dram_ccinv", a_ccinv, 2'b00);
    chk("sn_dram_dwait", a_dwait, 2'b11); adv();
    ramstate = 2'd2; ramload = 32'h55;
    smp(); chk("sn_acc_dwait", a_dwait, 2'b10); chk("sn_acc_dload", a_dload, 64'h55); adv();
    dREN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
    smp(); chk("sn_drop_ren", a_ramREN, 1'b0); chk("sn_drop_ccwait", a_ccwait, 2'b00);
    chk("sn_drop_dwait", a_dwait, 2'b11); adv();

    // burst lock: core1 two words before core0
    do_reset();
    dWEN = 2'b10; daddr[63:32] = 32'h200; dstore[63:32] = 32'h1; ramstate = 2'd2;
    smp(); chk("bl_idle_dwait", a_dwait, 2'b11); adv();
    dREN = 2'b01; daddr[31:0] = 32'h600;
    smp(); chk("bl_w0_wen", a_ramWEN, 1'b1); chk("bl_w0_ren", a_ramREN, 1'b0);
    chk("bl_w0_addr", a_ramaddr, 32'h200); chk("bl_w0_store", a_ramstore, 32'h1);
    chk("bl_w0_dwait", a_dwait, 2'b01); adv();
    daddr[63:32] = 32'h204; dstore[63:32] = 32'h2;
    smp(); chk("bl_w1_addr", a_ramaddr, 32'h204); chk("bl_w1_store", a_ramstore, 32'h2);
    chk("bl_w1_dwait", a_dwait, 2'b01); adv();
    dWEN = 2'b00;
    smp(); chk("bl_idle2_dwait", a_dwait, 2'b11); chk("bl_idle2_wen", a_ramWEN, 1'b0); adv();
    smp(); chk("bl_c0_ren", a_ramREN, 1'b1); chk("bl_c0_addr", a_ramaddr, 32'h600);
    chk("bl_c0_dwait", a_dwait, 2'b10); adv();
    dREN = 2'b00;

    // owner drops dREN mid-DRAM
    do_reset();
    dREN = 2'b01; daddr[31:0] = 32'h700; ramstate = 2'd1;
    adv();
    smp(); chk("ab_ren", a_ramREN, 1'b1); chk("ab_addr", a_ramaddr, 32'h700);
    chk("ab_dwait", a_dwait, 2'b11); adv();
    dREN = 2'b00; ramstate = 2'd2; ramload = 32'h99;
    smp(); chk("ab_drop_ren", a_ramREN, 1'b0); chk("ab_drop_dwait", a_dwait, 2'b11);
    chk("ab_drop_dload", a_dload, 64'h0); adv();
    smp(); chk("ab_idle_dwait", a_dwait, 2'b11); chk("ab_idle_ren", a_ramREN, 1'b0); adv();

    // reset asserted mid-IRAM
    do_reset();
    iREN = 2'b10; iaddr[63:32] = 32'h900; ramstate = 2'd1;
    adv();
    smp(); chk("rs_ren", a_ramREN, 1'b1); chk("rs_addr", a_ramaddr, 32'h900); adv();
    RST = 1'b1; ramstate = 2'd2; ramload = 32'h77;
    smp(); chk("rs_rst_iwait", a_iwait, 2'b11); chk("rs_rst_ren", a_ramREN, 1'b0);
    chk("rs_rst_iload", a_iload, 64'h0); adv();
    RST = 1'b0; iREN = 2'b00; ramstate = 2'd0; ramload = 32'h0;
    smp(); chk_reset_outs("rs_after"); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
